// File: rtl/dt_peak_scan_pkg.sv
// Shared definitions for the distance-transform peak scanner: FSM state
// encoding and image geometry used by the DT core.
package dt_peak_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int IMG_W   = 128;
  localparam int IMG_H   = 128;
  localparam int PIX_CNT = IMG_W * IMG_H;

endpackage

// File: rtl/dt_peak_acc.sv
// Peak/count accumulator for the DT peak scanner: tracks the strict maximum
// with its lowest address and counts nonzero pixels. Optional threshold
// counter is enabled by DT_PEAK_THRESH_EN.
module dt_peak_acc
  import dt_peak_scan_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              valid,
  input  logic [DATA_W-1:0] datum,
  input  logic [ADDR_W-1:0] addr,
`ifdef DT_PEAK_THRESH_EN
  input  logic [DATA_W-1:0] thresh,
  output logic [ADDR_W:0]   thr_cnt,
`endif
  output logic [DATA_W-1:0] peak_val,
  output logic [ADDR_W-1:0] peak_addr,
  output logic [ADDR_W:0]   obj_cnt
);

  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  // Strict compare keeps the first (lowest) address on ties since data
  // arrives in ascending address order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      peak_val  <= '0;
      peak_addr <= '0;
      obj_cnt   <= '0;
    end else if (clear) begin
      peak_val  <= '0;
      peak_addr <= '0;
      obj_cnt   <= '0;
    end else if (valid) begin
      if (datum > peak_val) begin
        peak_val  <= datum;
        peak_addr <= addr;
      end
      if (datum != '0) begin
        obj_cnt <= obj_cnt + CNT_ONE;
      end
    end
  end

`ifdef DT_PEAK_THRESH_EN
  logic [DATA_W-1:0] thresh_q;

  // The threshold is captured when a scan is accepted so that the input may
  // change freely while the scan runs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      thresh_q <= '0;
      thr_cnt  <= '0;
    end else if (clear) begin
      thresh_q <= thresh;
      thr_cnt  <= '0;
    end else if (valid && (datum >= thresh_q)) begin
      thr_cnt <= thr_cnt + CNT_ONE;
    end
  end
`endif

endmodule

// File: rtl/dt_peak_scan.sv
// Distance-map peak scanner: streams the whole result RAM once per start and
// reports the peak value, its lowest address and the nonzero pixel count.
// Optional threshold counting is enabled by DT_PEAK_THRESH_EN.
module dt_peak_scan
  import dt_peak_scan_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              res_rd,
  output logic [ADDR_W-1:0] res_addr,
  input  logic [DATA_W-1:0] res_di,
`ifdef DT_PEAK_THRESH_EN
  input  logic [DATA_W-1:0] thresh,
  output logic [ADDR_W:0]   thr_cnt,
`endif
  output logic [DATA_W-1:0] peak_val,
  output logic [ADDR_W-1:0] peak_addr,
  output logic [ADDR_W:0]   obj_cnt
);

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] addr_d;
  logic              valid_d;
  logic              accept;
  logic              last_addr;

  assign accept    = (state == IDLE) && start;
  assign last_addr = (addr_cnt == {ADDR_W{1'b1}});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SCAN;
      SCAN:    if (last_addr) next_state = DRAIN;
      DRAIN:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == SCAN) || (state == DRAIN);
    done     = (state == DONE);
    res_rd   = (state == SCAN);
    res_addr = (state == SCAN) ? addr_cnt : '0;
  end

  // The counter returns to zero after the final address so a scan can never
  // roll into a second pass.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_cnt <= '0;
    end else if (accept) begin
      addr_cnt <= '0;
    end else if (state == SCAN) begin
      addr_cnt <= last_addr ? '0 : addr_cnt + ADDR_W'(1);
    end
  end

  // RAM data lags the address by one cycle; delay address and strobe to match.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_d <= 1'b0;
      addr_d  <= '0;
    end else begin
      valid_d <= (state == SCAN);
      addr_d  <= addr_cnt;
    end
  end

  dt_peak_acc #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_acc (
    .clk      (clk),
    .reset    (reset),
    .clear    (accept),
    .valid    (valid_d),
    .datum    (res_di),
    .addr     (addr_d),
`ifdef DT_PEAK_THRESH_EN
    .thresh   (thresh),
    .thr_cnt  (thr_cnt),
`endif
    .peak_val (peak_val),
    .peak_addr(peak_addr),
    .obj_cnt  (obj_cnt)
  );

endmodule

// File: tb/tb_dt_peak_scan.sv
// Scoreboard bench for dt_peak_scan with a behavioural result RAM; the
// threshold checks are compiled in when DT_PEAK_THRESH_EN is defined.
module tb_dt_peak_scan;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;
  localparam int NPIX   = 1 << ADDR_W;

  typedef struct {
    logic [DATA_W-1:0] val;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   thr;
    int                done_cyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              busy;
  logic              done;
  logic              res_rd;
  logic [ADDR_W-1:0] res_addr;
  logic [DATA_W-1:0] res_di = '0;
  logic [DATA_W-1:0] peak_val;
  logic [ADDR_W-1:0] peak_addr;
  logic [ADDR_W:0]   obj_cnt;
  logic [DATA_W-1:0] thresh = 8'd3;
  logic [ADDR_W:0]   thr_cnt;

  logic [DATA_W-1:0] mem [0:NPIX-1];
  exp_t              sb[$];
  int                cyc = 0;
  int                tests_run = 0;
  int                fails = 0;

  dt_peak_scan #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .res_rd   (res_rd),
    .res_addr (res_addr),
    .res_di   (res_di),
`ifdef DT_PEAK_THRESH_EN
    .thresh   (thresh),
    .thr_cnt  (thr_cnt),
`endif
    .peak_val (peak_val),
    .peak_addr(peak_addr),
    .obj_cnt  (obj_cnt)
  );

`ifndef DT_PEAK_THRESH_EN
  assign thr_cnt = '0;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read RAM model: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (res_rd) res_di <= mem[res_addr];
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset && done) begin
      if (sb.size() == 0) begin
        tests_run++;
        fails++;
        $display("[TB] FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        e = sb.pop_front();
        check_output("done_cycle", cyc, e.done_cyc);
        check_output("peak_val", 32'(peak_val), 32'(e.val));
        check_output("peak_addr", 32'(peak_addr), 32'(e.addr));
        check_output("obj_cnt", 32'(obj_cnt), 32'(e.cnt));
`ifdef DT_PEAK_THRESH_EN
        check_output("thr_cnt", 32'(thr_cnt), 32'(e.thr));
`endif
      end
    end
  end

  task automatic fill_const(input logic [DATA_W-1:0] v);
    for (int i = 0; i < NPIX; i++) mem[i] = v;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_output({tag, "_busy"}, 32'(busy), 0);
    check_output({tag, "_done"}, 32'(done), 0);
    check_output({tag, "_res_rd"}, 32'(res_rd), 0);
    check_output({tag, "_res_addr"}, 32'(res_addr), 0);
  endtask

  task automatic check_zero_results(input string tag);
    check_output({tag, "_peak_val"}, 32'(peak_val), 0);
    check_output({tag, "_peak_addr"}, 32'(peak_addr), 0);
    check_output({tag, "_obj_cnt"}, 32'(obj_cnt), 0);
`ifdef DT_PEAK_THRESH_EN
    check_output({tag, "_thr_cnt"}, 32'(thr_cnt), 0);
`endif
  endtask

  task automatic apply_stimulus(input string name, input logic [DATA_W-1:0] val,
                                input logic [ADDR_W-1:0] addr, input logic [ADDR_W:0] cnt,
                                input logic [ADDR_W:0] thr, input bit repulse);
    exp_t e;
    int   n;
    @(negedge clk);
    e.val      = val;
    e.addr     = addr;
    e.cnt      = cnt;
    e.thr      = thr;
    e.done_cyc = cyc + 1 + NPIX + 1;
    sb.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_output({name, "_busy_scan"}, 32'(busy), 1);
    check_output({name, "_res_rd_scan"}, 32'(res_rd), 1);
    if (repulse) begin
      repeat (100) @(negedge clk);
      thresh = '0;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (!done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      tests_run++;
      fails++;
      $display("[TB] FAIL %s_timeout: got no done after %0d cycles, expected done", name, n);
    end
    thresh = 8'd3;
    repeat (3) @(negedge clk);
    check_idle_outputs({name, "_after"});
    check_output({name, "_hold_peak_val"}, 32'(peak_val), 32'(val));
    check_output({name, "_hold_peak_addr"}, 32'(peak_addr), 32'(addr));
    check_output({name, "_hold_obj_cnt"}, 32'(obj_cnt), 32'(cnt));
  endtask

  initial begin
    #1;
    check_idle_outputs("reset");
    check_zero_results("reset");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    fill_const(8'd0);
    apply_stimulus("all_zero", 8'd0, 14'd0, 15'd0, 15'd0, 1'b0);

    fill_const(8'd0);
    mem[16383] = 8'd200;
    apply_stimulus("last_pixel", 8'd200, 14'd16383, 15'd1, 15'd1, 1'b0);

    fill_const(8'd1);
    mem[5000] = 8'd7;
    mem[9000] = 8'd7;
    apply_stimulus("tie_repulse", 8'd7, 14'd5000, 15'd16384, 15'd2, 1'b1);

    // Abort a scan with reset; nothing is expected from the aborted run.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8000) @(negedge clk);
    reset = 1'b0;
    #1;
    check_idle_outputs("midscan_reset");
    check_zero_results("midscan_reset");
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check_output("post_reset_wait_busy", 32'(busy), 0);

    fill_const(8'd1);
    apply_stimulus("all_one", 8'd1, 14'd0, 15'd16384, 15'd0, 1'b0);

`ifdef DT_PEAK_THRESH_EN
    for (int i = 0; i < NPIX; i++) mem[i] = 8'(i % 8);
    apply_stimulus("ramp_thresh", 8'd7, 14'd7, 15'd14336, 15'd10240, 1'b0);
`endif

    repeat (5) @(negedge clk);
    check_output("scoreboard_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/dt_peak_scan.md
DT_PEAK_SCAN -- requirements
Module: dt_peak_scan

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, meaning res memory address width (128x128 image).
REQ-002 SHALL have parameter DATA_W, default 8, meaning distance value width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a scan, sampled in IDLE only.
REQ-006 SHALL have port busy  output  1  high while in SCAN or DRAIN.
REQ-007 SHALL have port done  output  1  one-cycle pulse when results are valid.
REQ-008 SHALL have port res_rd  output  1  read strobe to the distance-map RAM.
REQ-009 SHALL have port res_addr  output  ADDR_W  read address, row-major (y*128+x).
REQ-010 SHALL have port res_di  input  DATA_W  read data, valid the cycle after res_rd/res_addr.
REQ-011 SHALL have port peak_val  output  DATA_W  maximum distance found.
REQ-012 SHALL have port peak_addr  output  ADDR_W  lowest address holding peak_val.
REQ-013 SHALL have port obj_cnt  output  ADDR_W+1  count of nonzero pixels (0..16384).

Function
REQ-014 SHALL implement states IDLE, SCAN, DRAIN, DONE; reset state IDLE.
REQ-015 IDLE->SCAN when start=1; start in any other state SHALL be ignored.
REQ-016 On IDLE->SCAN the address counter, peak_val, peak_addr and obj_cnt SHALL be cleared to 0.
REQ-017 SCAN SHALL drive res_rd=1 and res_addr=counter, incrementing by 1 each cycle; one read per cycle, no bubbles.
REQ-018 SCAN->DRAIN after the cycle issuing address 2^ADDR_W-1; counter SHALL not wrap into a second pass.
REQ-019 DRAIN SHALL drive res_rd=0 and consume the last datum; DRAIN->DONE unconditionally.
REQ-020 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-021 Each datum arriving on res_di (cycle after issue) SHALL be processed with its delayed address: if res_di > peak_val (strict), peak_val<=res_di and peak_addr<=that address.
REQ-022 Ties SHALL keep the earlier (lower) address.
REQ-023 obj_cnt SHALL increment for every res_di != 0; width ADDR_W+1 so 16384 is representable without overflow.
REQ-024 Latency: start sampled at edge k -> SCAN k+1..k+16384, DRAIN k+16385, done high in cycle k+16386.
REQ-025 All-zero image SHALL yield peak_val=0, peak_addr=0, obj_cnt=0.
REQ-026 peak_val, peak_addr, obj_cnt SHALL hold after done until the next accepted start.
REQ-027 res_addr SHALL be 0 and res_rd 0 outside SCAN.

Reset
REQ-028 reset low SHALL asynchronously force IDLE, busy=0, done=0, res_rd=0, res_addr=0, peak_val=0, peak_addr=0, obj_cnt=0, including mid-scan; no partial result survives.
REQ-029 After reset release the block SHALL wait for a fresh start.

Configuration
REQ-030 Macro DT_PEAK_THRESH_EN defined SHALL add input thresh (DATA_W) and output thr_cnt (ADDR_W+1) counting pixels with res_di >= thresh; thresh SHALL be sampled at the accepted start and held for the scan; thr_cnt resets/clears like obj_cnt.
REQ-031 Without DT_PEAK_THRESH_EN the thresh/thr_cnt ports and logic SHALL be absent; all other behaviour identical.

Structure
REQ-032 Shared package SHALL hold the state enum, IMG_W=128, IMG_H=128 and the derived pixel count constant, reused by the DT core.
REQ-033 One sub-module dt_peak_acc SHALL hold the compare/update and counters, fed by datum, delayed address and valid; FSM/address generation stay in the top.

Verification
REQ-034 All-zero RAM, start -> done at start+16386 cycles, peak_val=0, peak_addr=0, obj_cnt=0.
REQ-035 RAM[5000]=7, RAM[9000]=7, others 1 -> peak_val=7, peak_addr=5000, obj_cnt=16384.
REQ-036 Single value RAM[16383]=200, rest 0 -> peak_val=200, peak_addr=16383, obj_cnt=1 (last-datum DRAIN path).
REQ-037 reset pulsed at scan cycle 8000, then new start on all-1 RAM -> outputs zeroed at reset; final peak_val=1, peak_addr=0, obj_cnt=16384.
REQ-038 start re-pulsed during SCAN -> ignored, single done pulse, results unchanged from an undisturbed run.
REQ-039 With DT_PEAK_THRESH_EN, thresh=3, RAM values 0..7 repeating -> thr_cnt=10240.
